// File: rtl/cpu_hpm.sv
// Machine counter and performance-monitor CSR bank: mcycle, minstret, programmable
// mhpmcounters with event selectors, and mcountinhibit on the shared CSR ports.
module cpu_hpm #(
  parameter int NUM_COUNTERS  = 4,
  parameter int NUM_EVENTS    = 8,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    retired_i,
  input  logic [NUM_EVENTS-1:0]   events_i,
  input  logic [11:0]             csr_read_addr_i,
  input  logic                    csr_read_enable_i,
  output logic [31:0]             csr_read_data_o,
  output logic                    csr_read_illegal_o,
  input  logic [11:0]             csr_write_addr_i,
  input  logic [31:0]             csr_write_data_i,
  input  logic [1:0]              csr_write_op_i,
  output logic [NUM_COUNTERS+2:0] overflow_o
);

  localparam int NumIdx = NUM_COUNTERS + 3;
  localparam int IdxW   = $clog2(NumIdx);
  localparam int SelW   = $clog2(NUM_EVENTS + 1);
  localparam logic [31:0] InhibitMask = ((32'd1 << NumIdx) - 32'd1) & ~32'd2;

  typedef enum logic [2:0] {
    KindNone,
    KindCntLo,
    KindCntHi,
    KindEvent,
    KindInhibit
  } kind_e;

  typedef struct packed {
    kind_e           kind;
    logic            mirror;
    logic [IdxW-1:0] idx;
  } dec_t;

  logic [COUNTER_WIDTH-1:0] counter_q [NumIdx];
  logic [COUNTER_WIDTH-1:0] counter_d [NumIdx];
  logic [SelW-1:0]          select_q  [NumIdx];
  logic [SelW-1:0]          select_d  [NumIdx];
  logic [31:0]              inhibit_q, inhibit_d;
  logic [NumIdx-1:0]        overflow_q, overflow_d;
  logic [NumIdx-1:0]        inc;
  logic [31:0]              readData_q, readData_d;
  logic                     readIllegal_q, readIllegal_d;
  logic [NUM_EVENTS:0]      eventsExt;
  dec_t                     rdDec, wrDec;
  logic [31:0]              wrOld, wrNew;
  logic                     wrEn;

  // Index 1 (time) lives elsewhere, so it is never decoded as a counter here.
  function automatic dec_t decodeAddr(input logic [11:0] addr);
    dec_t       d;
    logic [4:0] idx;
    logic       cntOk;
    idx      = addr[4:0];
    cntOk    = (idx != 5'd1) && (int'(idx) < NumIdx);
    d.kind   = KindNone;
    d.mirror = 1'b0;
    d.idx    = idx[IdxW-1:0];
    case (addr[11:5])
      7'h58: if (cntOk) d.kind = KindCntLo;
      7'h5C: if (cntOk) d.kind = KindCntHi;
      7'h60: if (cntOk) begin d.kind = KindCntLo; d.mirror = 1'b1; end
      7'h64: if (cntOk) begin d.kind = KindCntHi; d.mirror = 1'b1; end
      7'h19: begin
        if (idx == 5'd0) d.kind = KindInhibit;
        else if ((idx >= 5'd3) && (int'(idx) < NumIdx)) d.kind = KindEvent;
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] regValue(input dec_t d);
    logic [31:0] v;
    case (d.kind)
      KindCntLo:   v = counter_q[d.idx][31:0];
      KindCntHi:   v = 32'(counter_q[d.idx][COUNTER_WIDTH-1:32]);
      KindEvent:   v = 32'(select_q[d.idx]);
      KindInhibit: v = inhibit_q;
      default:     v = '0;
    endcase
    return v;
  endfunction

  // Bit 0 of the extended vector is a constant 0 so selector 0 never counts.
  assign eventsExt = {events_i, 1'b0};

  always_comb begin
    inc    = '0;
    inc[0] = ~inhibit_q[0];
    inc[2] = retired_i & ~inhibit_q[2];
    for (int i = 3; i < NumIdx; i++) begin
      inc[i] = eventsExt[select_q[i]] & ~inhibit_q[i];
    end
  end

  always_comb begin
    wrDec = decodeAddr(csr_write_addr_i);
    wrOld = regValue(wrDec);
    case (csr_write_op_i)
      2'b01:   wrNew = csr_write_data_i;
      2'b10:   wrNew = wrOld | csr_write_data_i;
      2'b11:   wrNew = wrOld & ~csr_write_data_i;
      default: wrNew = wrOld;
    endcase
    wrEn = (csr_write_op_i != 2'b00) && !wrDec.mirror && (wrDec.kind != KindNone);
  end

  // A write to either half replaces the whole increment for that counter.
  always_comb begin
    counter_d  = counter_q;
    select_d   = select_q;
    inhibit_d  = inhibit_q;
    overflow_d = '0;
    for (int i = 0; i < NumIdx; i++) begin
      if (inc[i]) begin
        counter_d[i]  = counter_q[i] + COUNTER_WIDTH'(1);
        overflow_d[i] = &counter_q[i];
      end
    end
    if (wrEn) begin
      case (wrDec.kind)
        KindCntLo: begin
          counter_d[wrDec.idx]  = {counter_q[wrDec.idx][COUNTER_WIDTH-1:32], wrNew};
          overflow_d[wrDec.idx] = 1'b0;
        end
        KindCntHi: begin
          counter_d[wrDec.idx]  = {wrNew[COUNTER_WIDTH-33:0], counter_q[wrDec.idx][31:0]};
          overflow_d[wrDec.idx] = 1'b0;
        end
        KindEvent:   select_d[wrDec.idx] = (wrNew > 32'(NUM_EVENTS)) ? '0 : wrNew[SelW-1:0];
        KindInhibit: inhibit_d = wrNew & InhibitMask;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdDec         = decodeAddr(csr_read_addr_i);
    readData_d    = '0;
    readIllegal_d = 1'b0;
    if (csr_read_enable_i) begin
      if (rdDec.kind == KindNone) readIllegal_d = 1'b1;
      else readData_d = regValue(rdDec);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NumIdx; i++) begin
        counter_q[i] <= '0;
        select_q[i]  <= '0;
      end
      inhibit_q     <= '0;
      overflow_q    <= '0;
      readData_q    <= '0;
      readIllegal_q <= 1'b0;
    end else begin
      counter_q     <= counter_d;
      select_q      <= select_d;
      inhibit_q     <= inhibit_d;
      overflow_q    <= overflow_d;
      readData_q    <= readData_d;
      readIllegal_q <= readIllegal_d;
    end
  end

  assign csr_read_data_o    = readData_q;
  assign csr_read_illegal_o = readIllegal_q;
  assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_cpu_hpm.sv
// Directed bench for cpu_hpm: a vector table for single-cycle behaviour plus
// hand-built sequences for inhibit timing and reset during a write.
module tb_cpu_hpm;

  localparam int NC = 4;
  localparam int NE = 8;
  localparam int CW = 64;
  localparam int NI = NC + 3;

  localparam logic [1:0] OpN = 2'b00;
  localparam logic [1:0] OpW = 2'b01;
  localparam logic [1:0] OpS = 2'b10;
  localparam logic [1:0] OpC = 2'b11;

  logic          clk;
  logic          reset;
  logic          retired;
  logic [NE-1:0] events;
  logic [11:0]   rdAddr;
  logic          rdEn;
  logic [31:0]   rdData;
  logic          rdIllegal;
  logic [11:0]   wrAddr;
  logic [31:0]   wrData;
  logic [1:0]    wrOp;
  logic [NI-1:0] overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         name;
    logic          rdEn;
    logic [11:0]   rdAddr;
    logic [1:0]    wrOp;
    logic [11:0]   wrAddr;
    logic [31:0]   wrData;
    logic [NE-1:0] events;
    logic          retired;
    logic          chkRd;
    logic [31:0]   expData;
    logic          expIll;
    logic [NI-1:0] expOvf;
  } vec_t;

  vec_t vecs[$];

  cpu_hpm #(
    .NUM_COUNTERS (NC),
    .NUM_EVENTS   (NE),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .retired_i         (retired),
    .events_i          (events),
    .csr_read_addr_i   (rdAddr),
    .csr_read_enable_i (rdEn),
    .csr_read_data_o   (rdData),
    .csr_read_illegal_o(rdIllegal),
    .csr_write_addr_i  (wrAddr),
    .csr_write_data_i  (wrData),
    .csr_write_op_i    (wrOp),
    .overflow_o        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input logic re, input logic [11:0] ra,
                              input logic [1:0] op, input logic [11:0] wa,
                              input logic [31:0] wd, input logic [NE-1:0] ev,
                              input logic ret, input logic chk, input logic [31:0] ed,
                              input logic ei, input logic [NI-1:0] eo);
    vec_t v;
    v.name = n; v.rdEn = re; v.rdAddr = ra; v.wrOp = op; v.wrAddr = wa;
    v.wrData = wd; v.events = ev; v.retired = ret; v.chkRd = chk;
    v.expData = ed; v.expIll = ei; v.expOvf = eo;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs are driven 1 time unit after an edge, outputs sampled 1 unit after the next.
  task automatic applyStimulus(input vec_t v);
    rdEn    = v.rdEn;
    rdAddr  = v.rdAddr;
    wrOp    = v.wrOp;
    wrAddr  = v.wrAddr;
    wrData  = v.wrData;
    events  = v.events;
    retired = v.retired;
    @(posedge clk);
    #1;
    if (v.chkRd) begin
      checkOutput({v.name, " data"}, rdData, v.expData);
      checkOutput({v.name, " illegal"}, 32'(rdIllegal), 32'(v.expIll));
    end
    checkOutput({v.name, " overflow"}, 32'(overflow), 32'(v.expOvf));
  endtask

  task automatic rd(input string n, input logic [11:0] a, input logic [31:0] e,
                    input logic ret);
    applyStimulus(mk(n, 1'b1, a, OpN, 12'h0, 32'h0, '0, ret, 1'b1, e, 1'b0, '0));
  endtask

  task automatic wr(input string n, input logic [11:0] a, input logic [31:0] d,
                    input logic ret);
    applyStimulus(mk(n, 1'b0, 12'h0, OpW, a, d, '0, ret, 1'b0, 32'h0, 1'b0, '0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; retired = 1'b0; events = '0;
    rdEn = 1'b1; rdAddr = 12'h7C0;
    wrOp = OpW; wrAddr = 12'hB03; wrData = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset data", rdData, 32'h0);
    checkOutput("reset illegal", 32'(rdIllegal), 32'h0);
    checkOutput("reset overflow", 32'(overflow), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      applyStimulus(mk("idle", 1'b0, 12'h0, OpN, 12'h0, 32'h0, '0, 1'b0, 1'b0, 32'h0, 1'b0, '0));
    rd("mcycle lo after 10", 12'hB00, 32'd10, 1'b0);
    rd("mcycle hi", 12'hB80, 32'd0, 1'b0);
    rd("minstret idle", 12'hB02, 32'd0, 1'b0);

    vecs.push_back(mk("sel3=2",      0, 12'h000, OpW, 12'h323, 32'd2,  8'h00, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("ev a",        0, 12'h000, OpN, 12'h000, 32'd0,  8'h02, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("ev b",        0, 12'h000, OpN, 12'h000, 32'd0,  8'h02, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("ev c",        0, 12'h000, OpN, 12'h000, 32'd0,  8'h03, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("ev d",        0, 12'h000, OpN, 12'h000, 32'd0,  8'h01, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("ev e",        0, 12'h000, OpN, 12'h000, 32'd0,  8'h02, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("ev f",        0, 12'h000, OpN, 12'h000, 32'd0,  8'h01, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("ev g",        0, 12'h000, OpN, 12'h000, 32'd0,  8'h02, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("hpm3 count",  1, 12'hB03, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'd5, 0, '0));
    vecs.push_back(mk("sel3 old",    1, 12'h323, OpW, 12'h323, NE + 1, 8'h00, 0, 1, 32'd2, 0, '0));
    vecs.push_back(mk("sel3 warl",   1, 12'h323, OpN, 12'h000, 32'd0,  8'hFF, 0, 1, 32'd0, 0, '0));
    vecs.push_back(mk("sel0 nocount",1, 12'hB03, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'd5, 0, '0));
    vecs.push_back(mk("sel3=8",      0, 12'h000, OpW, 12'h323, 32'd8,  8'h00, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("hpm3 lo ones",0, 12'h000, OpW, 12'hB03, 32'hFFFFFFFF, 8'h00, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("write wins",  0, 12'h000, OpW, 12'hB83, 32'hFFFFFFFF, 8'h80, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("wrap",        1, 12'hB03, OpN, 12'h000, 32'd0,  8'h80, 0, 1, 32'hFFFFFFFF, 0, 7'b0001000));
    vecs.push_back(mk("wrap hi",     1, 12'hB83, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'd0, 0, '0));
    vecs.push_back(mk("wrap lo",     1, 12'hB03, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'd0, 0, '0));
    vecs.push_back(mk("set lo",      0, 12'h000, OpS, 12'hB03, 32'hF0, 8'h00, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("clear lo",    0, 12'h000, OpC, 12'hB03, 32'h30, 8'h00, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("setclr read", 1, 12'hB03, OpW, 12'hB83, 32'd5,  8'h00, 0, 1, 32'hC0, 0, '0));
    vecs.push_back(mk("hi write",    1, 12'hB83, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'd5, 0, '0));
    vecs.push_back(mk("inh set F00", 0, 12'h000, OpS, 12'h320, 32'h0F00, 8'h00, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("inh clr 100", 0, 12'h000, OpC, 12'h320, 32'h0100, 8'h00, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("inh masked",  1, 12'h320, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'h0, 0, '0));
    vecs.push_back(mk("inh all",     0, 12'h000, OpW, 12'h320, 32'hFFFFFFFF, 8'h00, 0, 0, 32'h0, 0, '0));
    vecs.push_back(mk("inh warl",    1, 12'h320, OpN, 12'h000, 32'd0,  8'h80, 0, 1, 32'h7D, 0, '0));
    vecs.push_back(mk("inh frozen",  1, 12'hB03, OpW, 12'h320, 32'd0,  8'h00, 0, 1, 32'hC0, 0, '0));
    vecs.push_back(mk("ill 7C0",     1, 12'h7C0, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'h0, 1, '0));
    vecs.push_back(mk("ill 321",     1, 12'h321, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'h0, 1, '0));
    vecs.push_back(mk("ill B01",     1, 12'hB01, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'h0, 1, '0));
    vecs.push_back(mk("ill 327",     1, 12'h327, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'h0, 1, '0));
    vecs.push_back(mk("ill B87",     1, 12'hB87, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'h0, 1, '0));
    vecs.push_back(mk("mirror lo",   1, 12'hC03, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'hC0, 0, '0));
    vecs.push_back(mk("mirror hi",   1, 12'hC83, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'd5, 0, '0));
    vecs.push_back(mk("mirror wr",   1, 12'hB03, OpW, 12'hC03, 32'h1234, 8'h00, 0, 1, 32'hC0, 0, '0));
    vecs.push_back(mk("mirror ro",   1, 12'hB03, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'hC0, 0, '0));
    vecs.push_back(mk("rd off data", 0, 12'hB03, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'h0, 0, '0));
    vecs.push_back(mk("ill again",   1, 12'h7C0, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'h0, 1, '0));
    vecs.push_back(mk("rd off ill",  0, 12'h7C0, OpN, 12'h000, 32'd0,  8'h00, 0, 1, 32'h0, 0, '0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Inhibit freeze, resume, and the one-cycle lag of the inhibit write.
    wr("inh 5", 12'h320, 32'h5, 1'b0);
    wr("mcycle=100", 12'hB00, 32'd100, 1'b0);
    wr("minstret=7", 12'hB02, 32'd7, 1'b1);
    rd("frozen mcycle a", 12'hB00, 32'd100, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(mk("idle ret", 1'b0, 12'h0, OpN, 12'h0, 32'h0, '0, 1'b1, 1'b0, 32'h0, 1'b0, '0));
    rd("frozen mcycle b", 12'hB00, 32'd100, 1'b1);
    applyStimulus(mk("frozen minstret", 1'b1, 12'hB02, OpW, 12'h320, 32'h0, '0, 1'b1, 1'b1, 32'd7, 1'b0, '0));
    rd("resume lag", 12'hB00, 32'd100, 1'b1);
    rd("resume mcycle", 12'hB00, 32'd101, 1'b1);
    rd("resume minstret", 12'hB02, 32'd9, 1'b0);
    wr("inh 1", 12'h320, 32'h1, 1'b0);
    rd("inh lag mcycle", 12'hB00, 32'd104, 1'b0);
    rd("inh held mcycle", 12'hB00, 32'd104, 1'b0);
    wr("inh 0", 12'h320, 32'h0, 1'b0);

    // Reset asserted while a write and a read are in flight.
    reset = 1'b1; rdEn = 1'b1; rdAddr = 12'hB03;
    wrOp = OpW; wrAddr = 12'hB03; wrData = 32'hABCD;
    @(posedge clk);
    #1;
    checkOutput("rst flight data", rdData, 32'h0);
    checkOutput("rst flight illegal", 32'(rdIllegal), 32'h0);
    checkOutput("rst flight overflow", 32'(overflow), 32'h0);
    reset = 1'b0;
    rd("post rst mcycle", 12'hB00, 32'd0, 1'b0);
    rd("post rst hpm3 lo", 12'hB03, 32'd0, 1'b0);
    rd("post rst mcycle 2", 12'hB00, 32'd2, 1'b0);
    rd("post rst hpm3 hi", 12'hB83, 32'd0, 1'b0);
    rd("post rst sel3", 12'h323, 32'd0, 1'b0);
    rd("post rst inhibit", 12'h320, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
